// File: rtl/seq_signed_divider_pkg.sv
// Shared types and constants for the sequential signed divider.
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int CNT_W     = $clog2(DEF_WIDTH);

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_signed_divider_if #(
   parameter int WIDTH = 8
);

   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] R;
   logic             DivZero;
   logic             Ovf;

   modport master (
      output Start, A, B,
      input  Busy, Done, Q, R, DivZero, Ovf
   );

   modport slave (
      input  Start, A, B,
      output Busy, Done, Q, R, DivZero, Ovf
   );

endinterface

// File: rtl/seq_signed_divider_div_step_cell.sv
// One restoring-division step: shift in a dividend bit, trial-subtract,
// keep or restore the partial remainder.
module div_step_cell #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_o
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;

   // One extra top bit makes the trial difference's sign explicit.
   always_comb begin
      shifted = {rem_i, bit_i};
      trial   = shifted - {2'b00, dvs_i};
      q_o     = ~trial[WIDTH+1];
      rem_o   = q_o ? trial[WIDTH:0] : shifted[WIDTH:0];
   end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: restoring division on magnitudes, one
// quotient bit per clock, then sign fix-up and special cases.
module seq_signed_divider
   import seq_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input logic            CLK,
   input logic            RST,
   seq_signed_divider_if.slave bus
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic             sb_q, sb_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             dz_q, dz_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   step_rem;
   logic             step_q;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   div_step_cell #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_i(rem_q),
      .bit_i(dvd_q[WIDTH-1]),
      .dvs_i(dvs_q),
      .rem_o(step_rem),
      .q_o  (step_q)
   );

   // Magnitudes are unsigned, so the most-negative value maps cleanly.
   assign a_mag = bus.A[WIDTH-1] ? -bus.A : bus.A;
   assign b_mag = bus.B[WIDTH-1] ? -bus.B : bus.B;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      a_d     = a_q;
      sb_d    = sb_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.Start) begin
               a_d     = bus.A;
               sb_d    = bus.B[WIDTH-1];
               dvd_d   = a_mag;
               dvs_d   = b_mag;
               rem_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            rem_d = step_rem;
            dvd_d = {dvd_q[WIDTH-2:0], step_q};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (dvs_q == '0) begin
               q_d   = '1;
               r_d   = a_q;
               dz_d  = 1'b1;
               ovf_d = 1'b0;
            end else if (a_q == MOST_NEG && sb_q && dvs_q == ONE) begin
               q_d   = a_q;
               r_d   = '0;
               dz_d  = 1'b0;
               ovf_d = 1'b1;
            end else begin
               q_d   = (a_q[WIDTH-1] ^ sb_q) ? -dvd_q : dvd_q;
               r_d   = a_q[WIDTH-1] ? -rem_q[WIDTH-1:0]
                                    : rem_q[WIDTH-1:0];
               dz_d  = 1'b0;
               ovf_d = 1'b0;
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         a_q     <= '0;
         sb_q    <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         a_q     <= a_d;
         sb_q    <= sb_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.Busy    = busy_q;
   assign bus.Done    = done_q;
   assign bus.Q       = q_q;
   assign bus.R       = r_q;
   assign bus.DivZero = dz_q;
   assign bus.Ovf     = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed-vector bench for seq_signed_divider (WIDTH=8) with
// immediate assertions on timing, results and flags.
module tb_seq_signed_divider;

   localparam int W = 8;

   logic clk;
   logic rst;
   int   total;
   int   passed;
   logic [W-1:0] last_q;
   logic         seen_done;

   seq_signed_divider_if #(.WIDTH(W)) bus ();

   seq_signed_divider #(
      .WIDTH(W)
   ) u_dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one Start pulse; returns 1 time unit after accepting edge N.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.Start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      step();
      bus.Start = 1'b0;
      bus.A     = ~a;
      bus.B     = ~b;
   endtask

   task automatic run_op(input string tag,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input logic eovf);
      start_op(a, b);
      chk({tag, " busy@N"}, W'(bus.Busy), W'(1));
      for (int k = 1; k <= W + 2; k++) begin
         step();
         if (k == W) begin
            chk({tag, " done@N+W"}, W'(bus.Done), W'(0));
            chk({tag, " q_hold"}, bus.Q, last_q);
         end else if (k == W + 1) begin
            chk({tag, " done"}, W'(bus.Done), W'(1));
            chk({tag, " busy"}, W'(bus.Busy), W'(1));
            chk({tag, " Q"}, bus.Q, eq);
            chk({tag, " R"}, bus.R, er);
            chk({tag, " DivZero"}, W'(bus.DivZero), W'(edz));
            chk({tag, " Ovf"}, W'(bus.Ovf), W'(eovf));
         end else if (k == W + 2) begin
            chk({tag, " done_end"}, W'(bus.Done), W'(0));
            chk({tag, " busy_end"}, W'(bus.Busy), W'(0));
         end
      end
      last_q = eq;
   endtask

   initial begin
      total     = 0;
      passed    = 0;
      last_q    = '0;
      rst       = 1'b1;
      bus.Start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      #1;
      chk("rst Busy", W'(bus.Busy), W'(0));
      chk("rst Done", W'(bus.Done), W'(0));
      chk("rst Q", bus.Q, W'(0));
      chk("rst R", bus.R, W'(0));
      chk("rst DivZero", W'(bus.DivZero), W'(0));
      chk("rst Ovf", W'(bus.Ovf), W'(0));
      #20;
      @(negedge clk);
      rst = 1'b0;

      run_op("100/7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0);
      run_op("-100/7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0);
      run_op("100/-7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0);
      run_op("ovf", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
      run_op("div0", 8'd5, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0);
      run_op("127/-128", 8'd127, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0);
      run_op("-128/3", 8'h80, 8'd3, 8'hD6, 8'hFE, 1'b0, 1'b0);

      // Start re-pulsed during CALC and during DONE must be ignored.
      start_op(8'd20, 8'd3);
      for (int k = 1; k <= 3; k++) step();
      bus.Start = 1'b1;
      bus.A     = 8'd50;
      bus.B     = 8'd5;
      step();
      bus.Start = 1'b0;
      for (int k = 5; k <= W + 1; k++) step();
      chk("ign done", W'(bus.Done), W'(1));
      chk("ign Q", bus.Q, 8'h06);
      chk("ign R", bus.R, 8'h02);
      bus.Start = 1'b1;
      bus.A     = 8'd9;
      bus.B     = 8'd9;
      step();
      bus.Start = 1'b0;
      chk("ign busy_done", W'(bus.Busy), W'(0));
      step();
      chk("ign busy_after", W'(bus.Busy), W'(0));
      chk("ign Q_after", bus.Q, 8'h06);

      // Asynchronous reset during the 4th CALC cycle.
      start_op(8'd100, 8'd7);
      for (int k = 1; k <= 3; k++) step();
      #2;
      rst = 1'b1;
      #1;
      chk("abort Busy", W'(bus.Busy), W'(0));
      chk("abort Done", W'(bus.Done), W'(0));
      chk("abort Q", bus.Q, W'(0));
      chk("abort R", bus.R, W'(0));
      @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      for (int k = 0; k < W + 4; k++) begin
         step();
         if (bus.Done) seen_done = 1'b1;
      end
      chk("abort no_done", W'(seen_done), W'(0));
      last_q = '0;
      run_op("-7/2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
